// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, branch conditions and flag bit positions shared by the CPU blocks
package cpu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;
  localparam logic [3:0] OP_LHB = 4'b1010;
  localparam logic [3:0] OP_LLB = 4'b1011;
  localparam logic [3:0] OP_B = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [2:0] COND_NEQ = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GTE = 3'b100;
  localparam logic [2:0] COND_LTE = 3'b101;
  localparam logic [2:0] COND_OVFL = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/flag_next.sv
// flag_next: per-opcode flag write mask and candidate {N,V,Z} value from the ALU result
module flag_next
  import cpu_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [15:0] result,
  input  logic        ovfl,
  output logic [2:0]  mask,
  output logic [2:0]  val
);
  logic nvz_cls, z_cls;
  assign nvz_cls = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign z_cls = (opcode == OP_XOR) || (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
  always_comb begin
    val = '0;
    val[FLAG_N] = result[15];
    val[FLAG_V] = ovfl;
    val[FLAG_Z] = (result == 16'h0000);
    mask = '0;
    mask[FLAG_N] = nvz_cls;
    mask[FLAG_V] = nvz_cls;
    mask[FLAG_Z] = nvz_cls | z_cls;
  end
endmodule

// File: rtl/flag_reg_ctrl.sv
// flag_reg_ctrl: N/V/Z flag register with halt freeze and ID-stage branch interlock/bypass
module flag_reg_ctrl
  import cpu_pkg::*;
#(
  parameter bit FORWARD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic        ex_adv,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_result,
  input  logic        ex_ovfl,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic [2:0]  id_cond,
  output logic [2:0]  F,
  output logic        flag_hazard,
  output logic        flag_wr,
  output logic        halted
);
  state_t state, state_nxt;
  logic [2:0] flags, mask, val, merged;
  logic ex_live, commit, wr, dep;
  flag_next u_next (.opcode(ex_opcode), .result(ex_result), .ovfl(ex_ovfl), .mask(mask), .val(val));
  assign halted = (state == HALTED);
  assign ex_live = ex_valid & ~ex_flush & ~halted;
  assign commit = ex_live & ex_adv;
  assign wr = commit & |mask;
  assign merged = (flags & ~mask) | (val & mask);
  assign dep = id_valid & ((id_opcode == OP_B) | (id_opcode == OP_BR)) & (id_cond != COND_UNCOND);
  // rst_n gates the interlock so a reset during a stall releases ID at once
  assign flag_hazard = !FORWARD && rst_n && dep && ex_live && |mask;
  assign F = (FORWARD && ex_live) ? merged : flags;
  always_comb begin
    state_nxt = state;
    if (state == RUN && commit && ex_opcode == OP_HLT) state_nxt = HALTED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      flags <= '0;
      flag_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      flags <= wr ? merged : flags;
      flag_wr <= wr;
    end
  end
endmodule

// File: tb/tb_flag_reg_ctrl.sv
// tb_flag_reg_ctrl: directed checks on a non-forwarding and a forwarding instance driven in parallel
module tb_flag_reg_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid = 0, ex_flush = 0, ex_adv = 0, ex_ovfl = 0, id_valid = 0;
  logic [3:0] ex_opcode = 0, id_opcode = 0;
  logic [15:0] ex_result = 0;
  logic [2:0] id_cond = 0;
  logic [2:0] f0, f1;
  logic hz0, hz1, wr0, wr1, h0, h1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  flag_reg_ctrl #(.FORWARD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_adv(ex_adv), .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_cond(id_cond), .F(f0), .flag_hazard(hz0), .flag_wr(wr0), .halted(h0));
  flag_reg_ctrl #(.FORWARD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_adv(ex_adv), .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_cond(id_cond), .F(f1), .flag_hazard(hz1), .flag_wr(wr1), .halted(h1));
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic [3:0] op, input logic [15:0] r, input logic o);
    ex_valid = v; ex_opcode = op; ex_result = r; ex_ovfl = o;
  endtask
  initial begin
    #12;
    chk("rst_F", f0, 3'b000);
    chk("rst_halted", {2'b0, h0}, 3'b000);
    chk("rst_flag_wr", {2'b0, wr0}, 3'b000);
    rst_n = 1'b1;
    tick();
    ex_adv = 1;
    ex(1, 4'b0000, 16'h8000, 1);
    #1 chk("fwd_add_F", f1, 3'b110);
    tick();
    chk("add_F", f0, 3'b110);
    chk("add_wr", {2'b0, wr0}, 3'b001);
    ex(1, 4'b0001, 16'h0000, 0);
    #1 chk("fwd_sub_F", f1, 3'b001);
    tick();
    chk("sub_F", f0, 3'b001);
    chk("b2b_wr", {2'b0, wr0}, 3'b001);
    ex(1, 4'b0000, 16'h8000, 1);
    tick();
    ex(1, 4'b0010, 16'h0000, 0);
    tick();
    chk("xor_F", f0, 3'b111);
    ex(1, 4'b1000, 16'h0000, 0);
    tick();
    chk("lw_F", f0, 3'b111);
    chk("lw_wr", {2'b0, wr0}, 3'b000);
    ex(1, 4'b1001, 16'h1234, 1);
    tick();
    chk("sw_F", f0, 3'b111);
    chk("sw_wr", {2'b0, wr0}, 3'b000);
    ex(1, 4'b0000, 16'h0001, 0);
    id_valid = 1; id_opcode = 4'b1100; id_cond = 3'b001;
    #1 chk("hz_on", {2'b0, hz0}, 3'b001);
    chk("fwd_hz_off", {2'b0, hz1}, 3'b000);
    tick();
    chk("hz_add_F", f0, 3'b000);
    ex(0, 4'b0000, 16'h0001, 0);
    #1 chk("hz_one_cycle", {2'b0, hz0}, 3'b000);
    ex(1, 4'b0000, 16'h8000, 0);
    id_cond = 3'b111;
    #1 chk("hz_uncond", {2'b0, hz0}, 3'b000);
    id_cond = 3'b001; id_opcode = 4'b1101; ex_flush = 1;
    #1 chk("hz_flush", {2'b0, hz0}, 3'b000);
    tick();
    chk("flush_F", f0, 3'b000);
    chk("flush_wr", {2'b0, wr0}, 3'b000);
    ex_flush = 0; ex_adv = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hz", {2'b0, hz0}, 3'b001);
      tick();
      chk("stall_F", f0, 3'b000);
      chk("stall_wr", {2'b0, wr0}, 3'b000);
    end
    ex_adv = 1;
    #1 chk("stall_release_hz", {2'b0, hz0}, 3'b001);
    tick();
    chk("stall_commit_F", f0, 3'b100);
    ex(1, 4'b0001, 16'h0000, 0);
    id_opcode = 4'b1100;
    #1 chk("fwd_sub_hz", {2'b0, hz1}, 3'b000);
    chk("fwd_sub_Z", {2'b0, f1[0]}, 3'b001);
    chk("nofwd_sub_hz", {2'b0, hz0}, 3'b001);
    tick();
    chk("sub2_F", f0, 3'b001);
    ex(1, 4'b0000, 16'h8000, 1);
    id_valid = 0;
    tick();
    ex(1, 4'b1111, 16'h0000, 0);
    id_valid = 1;
    #1 chk("hlt_hz", {2'b0, hz0}, 3'b000);
    tick();
    chk("halted", {2'b0, h0}, 3'b001);
    chk("hlt_F", f0, 3'b110);
    ex(1, 4'b0000, 16'h0000, 0);
    #1 chk("halted_hz", {2'b0, hz0}, 3'b000);
    chk("halted_fwd_F", f1, 3'b110);
    tick();
    chk("halted_F", f0, 3'b110);
    chk("halted_wr", {2'b0, wr0}, 3'b000);
    chk("halted_hold", {2'b0, h0}, 3'b001);
    rst_n = 0;
    #1 chk("async_halted", {2'b0, h0}, 3'b000);
    chk("async_F", f0, 3'b000);
    chk("async_hz", {2'b0, hz0}, 3'b000);
    rst_n = 1;
    #1 chk("post_rst_hz", {2'b0, hz0}, 3'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
